disp_mode_ctrl: RTL
===================

# disp_mode_ctrl

Mode and time-set controller for the six-digit clock display. Selects which time source reaches the multiplexed 7-segment display driver (running clock, clock edit buffer, alarm, stopwatch) and drives its function-number digit. Provides BCD field editing with cursor blink, writes edited time back to the clock counter, and holds the alarm registers. It sits between the debounced key pulses and the clock counter on one side and the display driver on the other.

## Interface

Parameters:
- BLINK_HALF, 500, number of CP cycles per blink half-period; minimum 2.

Ports:
- CP  in  1  system clock, the same clock that drives the display scan.
- nCR  in  1  reset, asynchronous, active-low.
- key_mode  in  1  one-cycle pulse, debounced: advance mode.
- key_sel  in  1  one-cycle pulse: advance edit cursor.
- key_inc  in  1  one-cycle pulse: increment the field under the cursor.
- clk_hour, clk_minute, clk_second  in  8 each  running clock, packed BCD.
- sw_minute, sw_second  in  8 each  stopwatch value, packed BCD.
- hour, minute, second  out  8 each  packed BCD to the display driver.
- NUM  out  2  function number shown on the leftmost digit, equal to the current mode.
- set_hour, set_minute, set_second  out  8 each  new clock value; valid while set_we is high.
- set_we  out  1  one-cycle write strobe to the clock counter.
- ring  out  1  alarm match.

## Operation

- Modes, shown on NUM: 0 TIME, 1 SET, 2 ALARM, 3 STOPWATCH.
  - key_mode cycles 0→1→2→3→0.
  - Every mode change resets the cursor to 0 (hour) and restarts blink in the visible phase.
- TIME: display shows clk_hour:clk_minute:clk_second. key_sel and key_inc are ignored.
- SET:
  - On entry from TIME, the edit buffer loads the clk_* values sampled on that edge.
  - Cursor order is hour→minute→second→hour.
  - Display shows the edit buffer.
  - On leaving SET via key_mode: set_* = edit buffer and set_we = 1 for exactly one cycle.
- ALARM:
  - Cursor order is hour→minute→hour.
  - key_inc edits the internal alarm registers.
  - Display shows alm_hour:alm_minute:00.
- STOPWATCH: display shows 00:sw_minute:sw_second. key_sel and key_inc are ignored.
- BCD increment:
  - Minute and second: low nibble 9 → low nibble 0 and high nibble +1; 0x59 → 0x00.
  - Hour: 0x23 → 0x00; otherwise the same BCD rule (0x09→0x10, 0x19→0x20).
  - Inputs are always valid BCD; no repair of invalid codes.
- Blink:
  - A counter runs over 0..BLINK_HALF-1 and toggles the phase at wrap.
  - It is active only in SET and ALARM.
  - In the blank phase the field under the cursor is output as 8'hFF (display renders codes A–F blank).
  - key_sel and key_inc clear the counter and force the visible phase.
- ring = 1 while clk_hour==alm_hour && clk_minute==alm_minute, in every mode.
- Simultaneous keys: priority is key_mode > key_sel > key_inc. Lower-priority keys sampled on the same edge are dropped.

## Timing

- Reset values (nCR low, asynchronous): all of the following are 0.
  - Outputs: NUM, hour, minute, second, set_*, set_we, ring.
  - Internal state: mode, cursor, alarm registers, edit buffer, blink counter and phase.
  - Reset during SET discards the edit and no set_we is issued.
- State registers update on the CP edge that samples a key pulse (edge k). All outputs are registered and reflect the new state after edge k+1. Key-to-display latency is therefore 2 edges.
- set_we is high from edge k+1 to edge k+2 after key_mode is sampled in SET. set_* hold their value until the next write.
- Display data paths follow clk_*/sw_* with 1-cycle latency.
- ring follows the inputs with 1-cycle latency.
- Blink phase toggles every BLINK_HALF cycles: full blink period is 2·BLINK_HALF cycles.

## Test plan

- Reset: hold nCR low mid-operation → all outputs are 0 asynchronously. After release, NUM=0 and the display tracks clk_* = 12:34:56 two edges later.
- Set clock:
  - Stimulus: clk = 0x23:0x59:0x58, then key_mode, then key_inc, then key_sel + key_inc, then key_sel + key_inc, then key_mode.
  - Required: set_we pulses once with set = 00:00:59, and NUM sequence 0→1→2.
- Wrap: in SET, 10 key_inc on hour from 0x19 → 0x05 with the 0x23→0x00 wrap. 61 key_inc on minute from 0x00 → 0x01.
- Alarm:
  - Stimulus: set alarm to 07:30, then drive clk = 07:29:59 → 07:30:00.
  - Required: ring rises one cycle after the clk change and falls one cycle after clk reaches 07:31:00.
- Blink with BLINK_HALF=4: in SET with cursor on minute, minute alternates value/0xFF every 4 cycles while hour and second stay steady. key_inc mid-blank → visible on the next output update.
- Simultaneous keys: key_mode + key_inc in SET → mode advances to 2, the edit buffer is not incremented, and set_we carries the unincremented value.

Source files
------------

// File: rtl/disp_mode_ctrl.sv
// disp_mode_ctrl: display mode selection, BCD time editing with cursor blink, clock write-back and alarm registers
module disp_mode_ctrl #(
  parameter int BLINK_HALF = 500
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic [7:0] clk_hour,
  input  logic [7:0] clk_minute,
  input  logic [7:0] clk_second,
  input  logic [7:0] sw_minute,
  input  logic [7:0] sw_second,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [1:0] NUM,
  output logic [7:0] set_hour,
  output logic [7:0] set_minute,
  output logic [7:0] set_second,
  output logic       set_we,
  output logic       ring
);
  typedef enum logic [1:0] {M_TIME, M_SET, M_ALARM, M_STOPW} mode_t;
  localparam int CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_HALF - 1);
  mode_t mode, mode_n;
  logic [1:0] cur, cur_n;
  logic [7:0] eh, em, es, ah, am;
  logic [7:0] eh_n, em_n, es_n, ah_n, am_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ph, ph_n, pend, pend_n;
  logic [7:0] dh, dm, ds;
  logic edit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return v == top ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction

  assign edit = mode == M_SET || mode == M_ALARM;

  // state register: mode, cursor, edit buffer, alarm, blink and pending write
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      mode <= M_TIME;
      cur  <= 2'd0;
      eh   <= 8'h00;
      em   <= 8'h00;
      es   <= 8'h00;
      ah   <= 8'h00;
      am   <= 8'h00;
      cnt  <= '0;
      ph   <= 1'b0;
      pend <= 1'b0;
    end else begin
      mode <= mode_n;
      cur  <= cur_n;
      eh   <= eh_n;
      em   <= em_n;
      es   <= es_n;
      ah   <= ah_n;
      am   <= am_n;
      cnt  <= cnt_n;
      ph   <= ph_n;
      pend <= pend_n;
    end
  end

  // next state: key_mode beats key_sel beats key_inc, blink runs only while editing
  always_comb begin
    mode_n = mode;
    cur_n  = cur;
    eh_n   = eh;
    em_n   = em;
    es_n   = es;
    ah_n   = ah;
    am_n   = am;
    cnt_n  = cnt;
    ph_n   = ph;
    pend_n = 1'b0;
    if (key_mode) begin
      mode_n = mode_t'(mode + 2'd1);
      cur_n  = 2'd0;
      cnt_n  = '0;
      ph_n   = 1'b0;
      pend_n = mode == M_SET;
      if (mode == M_TIME) begin
        eh_n = clk_hour;
        em_n = clk_minute;
        es_n = clk_second;
      end
    end else if (edit) begin
      if (key_sel) begin
        cur_n = (mode == M_SET && cur != 2'd2) || (mode == M_ALARM && cur == 2'd0) ? cur + 2'd1 : 2'd0;
        cnt_n = '0;
        ph_n  = 1'b0;
      end else if (key_inc) begin
        cnt_n = '0;
        ph_n  = 1'b0;
        if (mode == M_SET) begin
          eh_n = cur == 2'd0 ? bcd_inc(eh, 8'h23) : eh;
          em_n = cur == 2'd1 ? bcd_inc(em, 8'h59) : em;
          es_n = cur == 2'd2 ? bcd_inc(es, 8'h59) : es;
        end else begin
          ah_n = cur == 2'd0 ? bcd_inc(ah, 8'h23) : ah;
          am_n = cur == 2'd1 ? bcd_inc(am, 8'h59) : am;
        end
      end else begin
        cnt_n = cnt == CMAX ? '0 : cnt + CW'(1);
        ph_n  = cnt == CMAX ? ~ph : ph;
      end
    end
  end

  // display source per mode, with the cursor field blanked in the blank phase
  always_comb begin
    dh = mode == M_TIME ? clk_hour : mode == M_SET ? eh : mode == M_ALARM ? ah : 8'h00;
    dm = mode == M_TIME ? clk_minute : mode == M_SET ? em : mode == M_ALARM ? am : sw_minute;
    ds = mode == M_TIME ? clk_second : mode == M_SET ? es : mode == M_ALARM ? 8'h00 : sw_second;
    dh = ph && cur == 2'd0 ? 8'hFF : dh;
    dm = ph && cur == 2'd1 ? 8'hFF : dm;
    ds = ph && cur == 2'd2 ? 8'hFF : ds;
  end

  // registered outputs: display, function number, clock write-back, alarm match
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      hour       <= 8'h00;
      minute     <= 8'h00;
      second     <= 8'h00;
      NUM        <= 2'd0;
      set_hour   <= 8'h00;
      set_minute <= 8'h00;
      set_second <= 8'h00;
      set_we     <= 1'b0;
      ring       <= 1'b0;
    end else begin
      hour       <= dh;
      minute     <= dm;
      second     <= ds;
      NUM        <= mode;
      set_hour   <= pend ? eh : set_hour;
      set_minute <= pend ? em : set_minute;
      set_second <= pend ? es : set_second;
      set_we     <= pend;
      ring       <= clk_hour == ah && clk_minute == am;
    end
  end
endmodule
